// File: rtl/fishingrod_pkg.sv
// Shared constants and FSM state encoding for the Fishingrod core scheduler.
package fishingrod_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Rounds the cipher core needs before its result is valid.
  localparam int ROUNDS = 18;
  localparam int WORD_W = 16;

endpackage

// File: rtl/fishingrod_rr_arb.sv
// Combinational round-robin arbiter: grants the first request found after rr.
module fishingrod_rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id
);

  int            idx;
  logic          found;
  logic [IW-1:0] sel;

  // Search rr+1, rr+2, ... wrapping, so the last winner is checked last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr) + k) % NREQ;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

endmodule

// File: rtl/fishingrod_sched.sv
// Round-robin scheduler sharing one Fishingrod core among NREQ requesters,
// with a start-to-ready watchdog and a per-requester response handshake.
module fishingrod_sched
  import fishingrod_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 32,
  parameter int TW      = 6
) (
  input  logic                   ck,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [WORD_W*NREQ-1:0] req_inp,
  input  logic [WORD_W*NREQ-1:0] req_key,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [WORD_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   core_start,
  output logic [WORD_W-1:0]      core_inp,
  output logic [WORD_W-1:0]      core_key,
  input  logic                   core_ready,
  input  logic [WORD_W-1:0]      core_out,
  output logic                   busy,
  output state_t                 dbg_state
);

  localparam int            IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  if (TIMEOUT <= ROUNDS || (1 << TW) <= TIMEOUT) begin : g_bad_params
    $error("fishingrod_sched: TIMEOUT must exceed ROUNDS and fit in TW bits");
  end

  state_t            state, state_nx;
  logic [IW-1:0]     rr, id;
  logic [TW-1:0]     wd;
  logic [NREQ-1:0]   gnt_oh;
  logic [IW-1:0]     gnt_id;
  logic              grant_fire, cap_ok, cap_to;
  logic [WORD_W-1:0] inp_w [NREQ];
  logic [WORD_W-1:0] key_w [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign inp_w[i] = req_inp[i*WORD_W +: WORD_W];
    assign key_w[i] = req_key[i*WORD_W +: WORD_W];
  end

  fishingrod_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req    (req_valid),
    .rr     (rr),
    .gnt    (gnt_oh),
    .gnt_id (gnt_id)
  );

  // Handshakes: a transfer happens on the rising edge where valid and ready
  // are both high; req_ready is offered only in IDLE, rsp_valid only in RESP.
  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    grant_fire = 1'b0;
    cap_ok     = 1'b0;
    cap_to     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_n && |gnt_oh) begin
          req_ready  = gnt_oh;
          grant_fire = 1'b1;
          state_nx   = LAUNCH;
        end
      end
      LAUNCH: begin
        core_start = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        // wd == 0 marks the first WAIT cycle, where core_ready may be stale.
        if (wd != '0 && core_ready) begin
          cap_ok   = 1'b1;
          state_nx = RESP;
        end else if (wd == WD_LAST) begin
          cap_to   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid[id] = 1'b1;
        if (rsp_ready[id]) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= IW'(NREQ - 1);
      id       <= '0;
      wd       <= '0;
      core_inp <= '0;
      core_key <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (grant_fire) begin
        core_inp <= inp_w[gnt_id];
        core_key <= key_w[gnt_id];
        id       <= gnt_id;
        rr       <= gnt_id;
      end
      if (state == LAUNCH)    wd <= '0;
      else if (state == WAIT) wd <= wd + 1'b1;
      if (cap_ok) begin
        rsp_data <= core_out;
        rsp_err  <= 1'b0;
      end else if (cap_to) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  a_req_ready_onehot: assert property (@(posedge ck) disable iff (!rst_n) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge ck) disable iff (!rst_n) $onehot0(rsp_valid));
  a_start_in_launch:  assert property (@(posedge ck) disable iff (!rst_n) core_start |-> (state == LAUNCH));

endmodule

// File: tb/tb_fishingrod_sched.sv
// Self-checking bench for fishingrod_sched: directed scenarios, then random traffic
// checked every cycle against a time-since-grant behavioural model.
module tb_fishingrod_sched;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 32;
  localparam int TW      = 6;

  // ---------------- clock / reset / DUT ----------------
  logic                 ck, rst_n;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [16*NREQ-1:0]   req_inp, req_key;
  logic [15:0]          rsp_data, core_inp, core_key, core_out;
  logic                 rsp_err, core_start, core_ready, busy;
  logic [1:0]           dbg_state;

  int cyc = 0;
  initial ck = 1'b0;
  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  fishingrod_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .ck(ck), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_inp(req_inp), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_inp(core_inp), .core_key(core_key),
    .core_ready(core_ready), .core_out(core_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- checking utilities ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] fake(input logic [15:0] a, input logic [15:0] k);
    return {a[7:0], a[15:8]} ^ k ^ 16'h9E37;
  endfunction

  // ---------------- core model (drives core_ready/core_out) ----------------
  logic [16:0] exp_q[$];          // {err, data} expected for each launched op
  bit          start_seen = 0;
  int          n_starts   = 0;
  int          core_lat   = 18;
  bit          core_never = 0, core_stale = 0, core_fix_en = 0, core_rand = 0;
  logic [15:0] core_fix_val = 16'h0;

  initial begin : core_proc
    int          k, lat;
    bit          nev, stl, fx;
    logic [15:0] base, fv;
    k = -1; lat = 1; nev = 0; stl = 0; fx = 0; base = '0; fv = '0;
    core_ready = 1'b0;
    core_out   = '0;
    forever begin
      @(posedge ck); #1;
      if (!rst_n) begin
        k = -1; core_ready = 1'b0; core_out = '0;
        exp_q.delete();
      end else begin
        if (start_seen) begin
          k    = 0;
          base = fake(core_inp, core_key);
          if (core_rand) begin
            nev = ($urandom_range(0, 7) == 0);
            stl = $urandom_range(0, 1);
            lat = $urandom_range(1, TIMEOUT - 1);
            fx  = 0;
          end else begin
            nev = core_never; stl = core_stale; lat = core_lat;
            fx  = core_fix_en; fv = core_fix_val;
          end
          exp_q.push_back(nev ? {1'b1, 16'h0000} : {1'b0, fx ? fv : (base ^ 16'(lat))});
        end else if (k >= 0 && k < 100000) begin
          k++;
        end
        if (k == 0) begin
          core_ready = stl;
          core_out   = stl ? 16'hDEAD : 16'($urandom);
        end else if (k > 0 && !nev && k >= lat) begin
          core_ready = 1'b1;
          core_out   = fx ? fv : (base ^ 16'(k));
        end else if (k > 0) begin
          core_ready = 1'b0;
          core_out   = 16'($urandom);
        end
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_busy = 0, m_in_resp = 0, m_err = 0;
  int          m_t = 0, m_id = 0, m_last = NREQ - 1;
  logic [15:0] m_inp = '0, m_key = '0, m_data = '0;

  initial begin : cmp
    int              w, c, wn;
    logic [NREQ-1:0] e_rr, e_rv;
    logic [16:0]     e;
    forever begin
      @(negedge ck);
      start_seen = core_start;
      if (core_start) n_starts++;
      if (!rst_n) begin
        m_busy = 0; m_in_resp = 0; m_err = 0; m_t = 0; m_id = 0;
        m_last = NREQ - 1; m_inp = '0; m_key = '0; m_data = '0;
      end
      // who would win if a grant is possible this cycle
      w = -1;
      if (rst_n && !m_busy)
        for (int j = 1; j <= NREQ; j++) begin
          c = (m_last + j) % NREQ;
          if (w < 0 && req_valid[c]) w = c;
        end
      e_rr = (w >= 0) ? NREQ'(1 << w) : '0;
      e_rv = (rst_n && m_in_resp) ? NREQ'(1 << m_id) : '0;
      chk("req_ready",  req_ready, e_rr);
      chk("rsp_valid",  rsp_valid, e_rv);
      chk("core_start", core_start, rst_n && m_busy && !m_in_resp && m_t == 1);
      chk("core_inp",   core_inp, m_inp);
      chk("core_key",   core_key, m_key);
      chk("rsp_data",   rsp_data, m_data);
      chk("rsp_err",    rsp_err, m_err);
      chk("busy",       busy, m_busy);
      chk("dbg_idle",   dbg_state == 2'd0, !m_busy);
      if (rst_n && (rsp_valid & rsp_ready) != '0) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_rsp", {rsp_err, rsp_data}, e);
        end
      end
      // advance the model to the next cycle
      if (rst_n) begin
        if (!m_busy) begin
          if (w >= 0) begin
            m_busy = 1; m_t = 1; m_id = w; m_last = w;
            m_inp = req_inp[w*16 +: 16];
            m_key = req_key[w*16 +: 16];
          end
        end else if (m_in_resp) begin
          if (rsp_ready[m_id]) begin m_busy = 0; m_in_resp = 0; end
        end else if (m_t == 1) begin
          m_t = 2;
        end else begin
          wn = m_t - 2;
          if (wn >= 1 && core_ready) begin
            m_data = core_out; m_err = 0; m_in_resp = 1;
          end else if (wn == TIMEOUT - 1) begin
            m_data = '0; m_err = 1; m_in_resp = 1;
          end else begin
            m_t++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output int id, output int at);
    bit ok;
    ok = 0; id = -1; at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ck);
      if (|req_ready) begin
        ok = 1; at = cyc;
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) id = j;
        break;
      end
    end
    chk("grant_wait", ok, 1);
  endtask

  task automatic wait_rsp(output int at);
    bit ok;
    ok = 0; at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ck);
      if (|rsp_valid) begin ok = 1; at = cyc; break; end
    end
    chk("rsp_wait", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge ck); #1;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    repeat (2) @(posedge ck);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_core(input int lat, input bit nev, input bit stl,
                          input bit fx, input logic [15:0] fv);
    core_lat = lat; core_never = nev; core_stale = stl;
    core_fix_en = fx; core_fix_val = fv; core_rand = 0;
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [15:0] t2_inp [NREQ];
  logic [15:0] t2_key [NREQ];

  initial begin : main
    int g, gc, rc;
    rst_n = 1'b1; req_valid = '0; rsp_ready = '0; req_inp = '0; req_key = '0;
    #1 rst_n = 1'b0; req_valid = '1;
    @(negedge ck);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    @(posedge ck); #1 rst_n = 1'b1; req_valid = '0;

    // T1: single request, 18-cycle core
    set_core(18, 0, 0, 1, 16'h5A5A);
    n_starts = 0;
    req_inp = {16'h0000, 16'h1234}; req_key = {16'h0000, 16'hABCD};
    rsp_ready = 2'b01; req_valid = 2'b01;
    wait_grant(g, gc);
    chk("t1_grant", g, 0);
    @(posedge ck); #1 req_valid = '0;
    wait_rsp(rc);
    chk("t1_latency", rc - gc, 21);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_data", rsp_data, 16'h5A5A);
    chk("t1_err", rsp_err, 0);
    chk("t1_core_inp", core_inp, 16'h1234);
    chk("t1_core_key", core_key, 16'hABCD);
    chk("t1_starts", n_starts, 1);

    // T2: both continuously valid, grants alternate from 0 after reset
    do_reset();
    set_core(5, 0, 0, 0, 16'h0);
    t2_inp[0] = 16'hCAFE; t2_inp[1] = 16'hBEEF;
    t2_key[0] = 16'h0304; t2_key[1] = 16'h0102;
    req_inp = {t2_inp[1], t2_inp[0]}; req_key = {t2_key[1], t2_key[0]};
    rsp_ready = 2'b11; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g, gc);
      chk("t2_order", g, i % 2);
      wait_rsp(rc);
      chk("t2_rsp_valid", rsp_valid, (g == 1) ? 2'b10 : 2'b01);
      if (g >= 0 && g < NREQ) chk("t2_data", rsp_data, fake(t2_inp[g], t2_key[g]) ^ 16'h0005);
    end
    @(posedge ck); #1 req_valid = '0;

    // T3: core never ready -> timeout, then a normal op
    set_core(5, 1, 0, 0, 16'h0);
    req_inp = {16'h7777, 16'h5555}; req_key = {16'h8888, 16'h6666};
    req_valid = 2'b01;
    wait_grant(g, gc);
    chk("t3_grant", g, 0);
    @(posedge ck); #1 req_valid = '0;
    wait_rsp(rc);
    chk("t3_latency", rc - gc, 34);
    chk("t3_data", rsp_data, 16'h0000);
    chk("t3_err", rsp_err, 1);
    @(posedge ck); #1;
    set_core(3, 0, 0, 1, 16'hC0DE);
    req_valid = 2'b10;
    wait_grant(g, gc);
    chk("t3_next_grant", g, 1);
    @(posedge ck); #1 req_valid = '0;
    wait_rsp(rc);
    chk("t3_next_data", rsp_data, 16'hC0DE);
    chk("t3_next_err", rsp_err, 0);
    @(posedge ck); #1;

    // T3b: ready arrives on the very last watchdog cycle -> result wins
    set_core(TIMEOUT - 1, 0, 0, 1, 16'h3131);
    req_valid = 2'b01;
    wait_grant(g, gc);
    @(posedge ck); #1 req_valid = '0;
    wait_rsp(rc);
    chk("t3b_latency", rc - gc, 34);
    chk("t3b_err", rsp_err, 0);
    chk("t3b_data", rsp_data, 16'h3131);
    @(posedge ck); #1;

    // T4: stale ready in the first WAIT cycle is ignored
    set_core(1, 0, 1, 0, 16'h0);
    req_inp = {16'h0F0F, 16'h0000}; req_key = {16'h1111, 16'h0000};
    req_valid = 2'b10;
    wait_grant(g, gc);
    chk("t4_grant", g, 1);
    @(posedge ck); #1 req_valid = '0;
    wait_rsp(rc);
    chk("t4_latency", rc - gc, 4);
    chk("t4_data", rsp_data, fake(16'h0F0F, 16'h1111) ^ 16'h0001);
    @(posedge ck); #1;

    // T5: response back-pressure blocks new grants
    set_core(2, 0, 0, 0, 16'h0);
    rsp_ready = '0;
    req_inp = {16'h2222, 16'h1111}; req_key = {16'h4444, 16'h3333};
    req_valid = 2'b01;
    wait_grant(g, gc);
    chk("t5_grant", g, 0);
    @(posedge ck); #1 req_valid = 2'b10;
    wait_rsp(rc);
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      chk("t5_hold_valid", rsp_valid, 2'b01);
      chk("t5_hold_data", rsp_data, fake(16'h1111, 16'h3333) ^ 16'h0002);
      chk("t5_no_grant", req_ready, 2'b00);
    end
    @(posedge ck); #1 rsp_ready = 2'b01;
    @(negedge ck);
    chk("t5_hs_valid", rsp_valid, 2'b01);
    @(negedge ck);
    chk("t5_regrant", req_ready, 2'b10);
    @(posedge ck); #1 req_valid = '0; rsp_ready = 2'b11;
    wait_rsp(rc);
    chk("t5_r1_valid", rsp_valid, 2'b10);
    @(posedge ck); #1;

    // T6: asynchronous reset during WAIT
    set_core(20, 0, 0, 0, 16'h0);
    req_inp = {16'h9999, 16'h6666}; req_key = {16'hAAAA, 16'hBBBB};
    req_valid = 2'b01;
    wait_grant(g, gc);
    @(posedge ck); #1 req_valid = '0;
    repeat (5) @(posedge ck);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_core_inp", core_inp, 0);
    chk("t6_core_key", core_key, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rsp_data", rsp_data, 0);
    chk("t6_core_start", core_start, 0);
    repeat (2) @(posedge ck);
    #1 rst_n = 1'b1; req_valid = 2'b11;
    wait_grant(g, gc);
    chk("t6_first_grant", g, 0);
    @(posedge ck); #1 req_valid = '0;
    wait_rsp(rc);
    @(posedge ck); #1;

    // Random traffic
    do_reset();
    core_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge ck); #1;
      req_valid = NREQ'($urandom);
      req_inp   = (16*NREQ)'($urandom);
      req_key   = (16*NREQ)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0) ? NREQ'($urandom) : '0;
    end
    @(posedge ck); #1 req_valid = '0; rsp_ready = '1;
    repeat (80) @(posedge ck);
    #1 chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/fishingrod_sched.md
Name: fishingrod_sched

Overview:
- Shares one Fishingrod cipher core between NREQ requesters.
- Arbitrates requests round-robin and holds data/key stable on the core.
- Pulses the core start, waits for core ready with a watchdog, captures the result and returns it through a valid/ready response handshake.
- Sits directly above the Fishingrod top; one operation is outstanding at a time.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 32, cycles allowed from core start to core ready before an error is returned (must exceed the 18-round latency).
- TW, 6, watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- ck  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_inp  in  16*NREQ  packed data words; requester i occupies bits [16i+15:16i]
- req_key  in  16*NREQ  packed key words, same packing
- rsp_valid  out  NREQ  per-requester response valid; one-hot or zero
- rsp_ready  in  NREQ  per-requester response accept
- rsp_data  out  16  result word; shared by all requesters
- rsp_err  out  1  timeout flag qualifying rsp_data
- core_start  out  1  one-cycle start pulse to the core
- core_inp  out  16  data to the core
- core_key  out  16  key to the core
- core_ready  in  1  core done level
- core_out  in  16  core result
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- **Clock and reset.** Single clock ck. rst_n low (asynchronous assertion, synchronous release) forces:
  - state IDLE, rr pointer = NREQ-1, watchdog = 0;
  - all outputs 0, including core_inp, core_key, rsp_data and rsp_err.
- **States:** IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - Grant goes to the first requester with req_valid set, searching from rr+1 upward modulo NREQ.
  - The granted requester sees req_ready=1 combinationally in the same cycle.
  - On that edge: latch its inp and key into core_inp/core_key, store the grant id, rr <= id, go to LAUNCH.
  - No valid request: stay in IDLE, req_ready=0.
- **LAUNCH** (exactly 1 cycle)
  - core_start=1, watchdog cleared; go to WAIT.
- **WAIT**
  - The watchdog increments each cycle.
  - core_ready is ignored in the first WAIT cycle, because the core's ready may still be stale from a prior run.
  - From the second WAIT cycle, core_ready=1: rsp_data <= core_out, rsp_err <= 0, go to RESP.
  - Watchdog reaches TIMEOUT with core_ready still 0: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - If both events fall on the same cycle, the core result wins (rsp_err=0).
- **RESP**
  - rsp_valid[id]=1; rsp_data and rsp_err are held stable.
  - rsp_ready[id]=1: go to IDLE. rsp_ready on other bits is ignored.
  - New requests are not granted until the cycle after the response handshake, so the earliest re-grant is the next IDLE cycle.
- **Core interface hold.** core_inp and core_key stay constant from LAUNCH through RESP and change only on a new grant.
- **Latency.** Grant at edge T, core_start during T+1, first qualifying ready at T+3 or later, rsp_valid from the edge after ready is sampled.
- **Round-robin.** After requester i is served, i has the lowest priority for the next grant. With all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. The first grant after reset goes to 0.
- **Reset mid-operation.** All state is discarded immediately and no response is delivered. The requester must re-issue.
- **Requester rules.**
  - A requester may drop req_valid before it is granted with no effect.
  - req_inp/req_key are sampled only on the grant edge.
- **Assertions.**
  - req_ready and rsp_valid are each one-hot or zero.
  - core_start is high only in LAUNCH.

Decomposition:
- Shared package fishingrod_pkg:
  - state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RESP=2'd3);
  - the 18-round count constant;
  - the word width of 16.
- One sub-module, fishingrod_rr_arb:
  - inputs: request vector and rr pointer;
  - outputs: one-hot grant plus encoded id;
  - purely combinational.
- The FSM, watchdog and capture registers live in fishingrod_sched.

Test Plan:
1. Single request: req_valid=01, inp=16'h1234, key=16'hABCD, core model ready after 18 cycles with out=16'h5A5A.
   - Expected: one core_start pulse, core_inp=1234 and core_key=ABCD held, rsp_valid=01, rsp_data=5A5A, rsp_err=0.
2. Both requesters valid continuously for 4 operations.
   - Expected: grant order 0,1,0,1; each response carries that requester's core result.
3. Core never asserts ready.
   - Expected: rsp_valid after TIMEOUT=32 WAIT cycles, rsp_data=0000, rsp_err=1.
   - Then the next request completes normally.
4. Stale core_ready held high at start.
   - Expected: ignored in the first WAIT cycle, captured in the second; rsp_data equals the core_out of that cycle.
5. rsp_ready held low for 10 cycles.
   - Expected: rsp_valid and rsp_data stay stable and no new grant occurs while requester 1 is valid.
   - Release: IDLE, then requester 1 is granted the next cycle.
6. rst_n pulsed low during WAIT.
   - Expected: all outputs 0 asynchronously and no rsp_valid.
   - After release, a fresh request is granted to requester 0 first.
